// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one FU result slot per cycle onto the Common Data Bus.
// Optional macro CDB_ARB_BRANCH_PRIO_EN: occupied branch slots win over non-branch slots.
package cdb_arbiter_pkg;
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] NPC;
        logic [4:0]  dest_reg_idx;
        logic        take_branch;
        logic        halt;
        logic        illegal;
        logic        valid;
    } EX_PACKET;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_FU-1:0]         fu_valid,
    input  EX_PACKET                  fu_packet [NUM_FU],
    input  logic [NUM_FU-1:0]         fu_correct_predict,
    input  logic [NUM_FU-1:0]         fu_no_output,
    input  logic [NUM_FU-1:0]         fu_is_branch,
    output logic [NUM_FU-1:0]         fu_ready,
    input  logic                      squash,
    output logic                      cdb_valid,
    output EX_PACKET                  cdb_packet,
    output logic                      cdb_correct_predict,
    output logic                      cdb_no_output,
    output logic [$clog2(NUM_FU)-1:0] cdb_grant_idx
);

    localparam int IDX_W = $clog2(NUM_FU);
    typedef logic [IDX_W-1:0] idx_t;

    logic [NUM_FU-1:0] occ_p0;
    EX_PACKET          slot_pkt_p0 [NUM_FU];
    logic [NUM_FU-1:0] slot_cp_p0;
    logic [NUM_FU-1:0] slot_no_p0;
    idx_t              rr_ptr;

    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] accept;
    idx_t              grant_idx;
    idx_t              rr_next;
    logic              grant_any;

    function automatic idx_t wrap_idx(input idx_t base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_FU) s = s - NUM_FU;
        return idx_t'(s);
    endfunction

`ifdef CDB_ARB_BRANCH_PRIO_EN
    logic [NUM_FU-1:0] slot_br_p0;
    logic [NUM_FU-1:0] br_req;

    assign br_req = occ_p0 & slot_br_p0;
    assign req    = (|br_req) ? br_req : occ_p0;
`else
    logic unused_is_branch;

    assign unused_is_branch = ^fu_is_branch;
    assign req              = occ_p0;
`endif

    // Descending scan so the slot closest to rr_ptr is written last and wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            if (req[wrap_idx(rr_ptr, k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_idx(rr_ptr, k);
            end
        end
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    assign rr_next  = (grant_idx == idx_t'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
    assign fu_ready = (reset && !squash) ? (~occ_p0 | grant) : '0;
    assign accept   = fu_valid & fu_ready;

    // Stage p0: holding slots (data only loads on accept; reset and squash gate fu_ready)
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                slot_pkt_p0[i] <= fu_packet[i];
                slot_cp_p0[i]  <= fu_correct_predict[i];
                slot_no_p0[i]  <= fu_no_output[i];
`ifdef CDB_ARB_BRANCH_PRIO_EN
                slot_br_p0[i]  <= fu_is_branch[i];
`endif
            end
        end
    end

    // Stage p1: CDB source registers, occupancy and round-robin pointer
    always_ff @(posedge clock) begin
        if (!reset) begin
            occ_p0              <= '0;
            rr_ptr              <= '0;
            cdb_valid           <= 1'b0;
            cdb_packet          <= '0;
            cdb_correct_predict <= 1'b0;
            cdb_no_output       <= 1'b0;
            cdb_grant_idx       <= '0;
        end else if (squash) begin
            occ_p0    <= '0;
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= grant_any;
            if (grant_any) begin
                cdb_packet          <= slot_pkt_p0[grant_idx];
                cdb_correct_predict <= slot_cp_p0[grant_idx];
                cdb_no_output       <= slot_no_p0[grant_idx];
                cdb_grant_idx       <= grant_idx;
                rr_ptr              <= rr_next;
            end
            occ_p0 <= (occ_p0 & ~grant) | accept;
        end
    end

endmodule
